// File: rtl/frame_source_scheduler.sv
// Frame source scheduler: owns the frame-buffer write port, steering either
// UART-assembled pixels or a single armed camera frame into it, then hands
// the buffer to the processing path and waits for it to finish.
//
// state          | meaning
// ---------------+----------------------------------------------------------
// ST_IDLE        | waiting for a command; cam_mode tracks mode_sel here only
// ST_UART_RX     | receiving UART pixels, checking the pixel index sequence
// ST_CAM_WAIT    | camera capture armed, waiting for the frame-start vsync
// ST_CAM_RX      | writing camera pixels until the frame is complete
// ST_PROC_START  | one-cycle proc_start, buffer handed to processing
// ST_PROC_WAIT   | processing owns the buffer until proc_done
module frame_source_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int COLOR_BITS   = 4,
    parameter int TOTAL_PIXELS = 9600,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode_sel,
    output logic                    cam_mode,
    input  logic                    uart_pixel_done,
    input  logic                    uart_frame_done,
    input  logic [ADDR_WIDTH-1:0]   uart_pixel_cnt,
    input  logic [3*DATA_WIDTH-1:0] uart_rgb,
    input  logic                    cam_vsync,
    input  logic                    cam_we,
    input  logic [ADDR_WIDTH-1:0]   cam_addr,
    input  logic [3*COLOR_BITS-1:0] cam_rgb,
    output logic                    fb_we,
    output logic [ADDR_WIDTH-1:0]   fb_addr,
    output logic [3*COLOR_BITS-1:0] fb_wdata,
    output logic                    fb_sel,
    output logic                    proc_start,
    input  logic                    proc_done,
    output logic                    busy,
    input  logic                    err_clr,
    output logic                    err_seq,
    output logic                    err_short,
    output logic                    err_overrun
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_UART_RX    = 3'd1,
        ST_CAM_WAIT   = 3'd2,
        ST_CAM_RX     = 3'd3,
        ST_PROC_START = 3'd4,
        ST_PROC_WAIT  = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(TOTAL_PIXELS - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   exp_cnt;
    logic [ADDR_WIDTH-1:0]   cam_cnt;
    logic [3*COLOR_BITS-1:0] uart_reduced;
    logic                    uart_any;

    // Keep the MSBs of each colour channel; the final pixel rides on frame_done.
    assign uart_reduced = {uart_rgb[3*DATA_WIDTH-1 -: COLOR_BITS],
                           uart_rgb[2*DATA_WIDTH-1 -: COLOR_BITS],
                           uart_rgb[DATA_WIDTH-1   -: COLOR_BITS]};
    assign uart_any     = uart_pixel_done | uart_frame_done;

    // Sequencing FSM with all outputs registered; flag sets are written after
    // err_clr so a simultaneous set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            exp_cnt     <= '0;
            cam_cnt     <= '0;
            cam_mode    <= 1'b0;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_wdata    <= '0;
            fb_sel      <= 1'b0;
            proc_start  <= 1'b0;
            busy        <= 1'b0;
            err_seq     <= 1'b0;
            err_short   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            fb_we      <= 1'b0;
            proc_start <= 1'b0;
            if (err_clr) begin
                err_seq     <= 1'b0;
                err_short   <= 1'b0;
                err_overrun <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    cam_mode <= mode_sel;
                    if (cam_mode) begin
                        if (uart_frame_done) begin
                            state <= ST_CAM_WAIT;
                            busy  <= 1'b1;
                        end
                    end else if (uart_frame_done) begin
                        fb_we      <= 1'b1;
                        fb_addr    <= uart_pixel_cnt;
                        fb_wdata   <= uart_reduced;
                        state      <= ST_PROC_START;
                        proc_start <= 1'b1;
                        fb_sel     <= 1'b1;
                        busy       <= 1'b1;
                    end else if (uart_pixel_done) begin
                        fb_we    <= 1'b1;
                        fb_addr  <= uart_pixel_cnt;
                        fb_wdata <= uart_reduced;
                        exp_cnt  <= uart_pixel_cnt + 1'b1;
                        state    <= ST_UART_RX;
                        busy     <= 1'b1;
                    end
                end
                ST_UART_RX: begin
                    if (uart_any) begin
                        fb_we    <= 1'b1;
                        fb_addr  <= uart_pixel_cnt;
                        fb_wdata <= uart_reduced;
                        if (uart_pixel_cnt != exp_cnt) begin
                            err_seq <= 1'b1;
                        end
                        if (uart_frame_done) begin
                            exp_cnt    <= '0;
                            state      <= ST_PROC_START;
                            proc_start <= 1'b1;
                            fb_sel     <= 1'b1;
                        end else begin
                            exp_cnt <= exp_cnt + 1'b1;
                        end
                    end
                end
                ST_CAM_WAIT: begin
                    if (cam_vsync) begin
                        cam_cnt <= '0;
                        state   <= ST_CAM_RX;
                    end
                end
                ST_CAM_RX: begin
                    if (cam_we) begin
                        fb_we    <= 1'b1;
                        fb_addr  <= cam_addr;
                        fb_wdata <= cam_rgb;
                        cam_cnt  <= cam_cnt + 1'b1;
                    end
                    if (cam_we && (cam_cnt == LAST_PIX)) begin
                        state      <= ST_PROC_START;
                        proc_start <= 1'b1;
                        fb_sel     <= 1'b1;
                    end else if (cam_vsync) begin
                        err_short  <= 1'b1;
                        state      <= ST_PROC_START;
                        proc_start <= 1'b1;
                        fb_sel     <= 1'b1;
                    end
                end
                ST_PROC_START: begin
                    if (uart_any) begin
                        err_overrun <= 1'b1;
                    end
                    state <= ST_PROC_WAIT;
                end
                ST_PROC_WAIT: begin
                    if (uart_any) begin
                        err_overrun <= 1'b1;
                    end
                    if (proc_done) begin
                        fb_sel <= 1'b0;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    fb_sel <= 1'b0;
                end
            endcase
        end
    end

endmodule
